// File: rtl/axi_decerr_slave.sv
// rtl/axi_decerr_slave.sv - AXI4 default-port responder: drains every burst, answers DECERR,
// and keeps a sticky record of the first offending access plus a saturating event count.
module axi_decerr_slave #(
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          IdWidth   = 5,
  parameter logic [DataWidth-1:0] RespData  = 64'hDEAD_BEEF_DEAD_BEEF,
  parameter int unsigned          CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic                 w_last_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic                 err_valid_o,
  output logic                 err_write_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic [CntWidth-1:0]  err_cnt_o,
  input  logic                 err_clr_i
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e             w_state_q;
  r_state_e             r_state_q;
  logic                 aw_ready_q, w_ready_q, b_valid_q;
  logic                 ar_ready_q, r_valid_q, r_last_q;
  logic [IdWidth-1:0]   b_id_q, r_id_q;
  logic [7:0]           beat_cnt_q;
  logic                 err_valid_q, err_valid_d;
  logic                 err_write_q, err_write_d;
  logic [AddrWidth-1:0] err_addr_q, err_addr_d;
  logic [CntWidth-1:0]  err_cnt_q, err_cnt_d;

  logic aw_hs, ar_hs;
  assign aw_hs = aw_valid_i & aw_ready_q;
  assign ar_hs = ar_valid_i & ar_ready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: if (aw_hs) begin
          b_id_q     <= aw_id_i;
          aw_ready_q <= 1'b0;
          w_ready_q  <= 1'b1;
          w_state_q  <= W_DATA;
        end
        W_DATA: if (w_valid_i && w_last_i) begin
          w_ready_q <= 1'b0;
          b_valid_q <= 1'b1;
          w_state_q <= W_RESP;
        end
        W_RESP: if (b_ready_i) begin
          b_valid_q  <= 1'b0;
          aw_ready_q <= 1'b1;
          w_state_q  <= W_IDLE;
        end
        default: begin
          w_state_q  <= W_IDLE;
          aw_ready_q <= 1'b1;
          w_ready_q  <= 1'b0;
          b_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  // r_last is precomputed one beat ahead so it is registered alongside r_valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (ar_hs) begin
          r_id_q     <= ar_id_i;
          beat_cnt_q <= ar_len_i;
          ar_ready_q <= 1'b0;
          r_valid_q  <= 1'b1;
          r_last_q   <= (ar_len_i == 8'd0);
          r_state_q  <= R_DATA;
        end
        R_DATA: if (r_ready_i) begin
          if (beat_cnt_q == 8'd0) begin
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            ar_ready_q <= 1'b1;
            r_state_q  <= R_IDLE;
          end else begin
            beat_cnt_q <= beat_cnt_q - 8'd1;
            r_last_q   <= (beat_cnt_q == 8'd1);
          end
        end
        default: begin
          r_state_q  <= R_IDLE;
          ar_ready_q <= 1'b1;
          r_valid_q  <= 1'b0;
          r_last_q   <= 1'b0;
        end
      endcase
    end
  end

  logic [1:0]          evt_inc;
  logic [CntWidth-1:0] cnt_base;
  logic [CntWidth:0]   cnt_sum;

  // A clear and an event in the same cycle: the clear zeroes the state, then the event lands on it.
  always_comb begin
    err_valid_d = err_valid_q;
    err_write_d = err_write_q;
    err_addr_d  = err_addr_q;
    err_cnt_d   = err_cnt_q;
    evt_inc     = {1'b0, aw_hs} + {1'b0, ar_hs};
    cnt_base    = err_clr_i ? '0 : err_cnt_q;
    cnt_sum     = {1'b0, cnt_base} + {{(CntWidth-1){1'b0}}, evt_inc};
    if (err_clr_i) begin
      err_valid_d = 1'b0;
      err_write_d = 1'b0;
      err_addr_d  = '0;
      err_cnt_d   = '0;
    end
    if (aw_hs || ar_hs) begin
      err_cnt_d = cnt_sum[CntWidth] ? {CntWidth{1'b1}} : cnt_sum[CntWidth-1:0];
      if (!err_valid_q || err_clr_i) begin
        err_valid_d = 1'b1;
        err_write_d = aw_hs;
        err_addr_d  = aw_hs ? aw_addr_i : ar_addr_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_q <= 1'b0;
      err_write_q <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_write_q <= err_write_d;
      err_addr_q  <= err_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign aw_ready_o  = aw_ready_q;
  assign w_ready_o   = w_ready_q;
  assign b_valid_o   = b_valid_q;
  assign b_id_o      = b_id_q;
  assign b_resp_o    = 2'b11;
  assign ar_ready_o  = ar_ready_q;
  assign r_valid_o   = r_valid_q;
  assign r_last_o    = r_last_q;
  assign r_id_o      = r_id_q;
  assign r_data_o    = RespData;
  assign r_resp_o    = 2'b11;
  assign err_valid_o = err_valid_q;
  assign err_write_o = err_write_q;
  assign err_addr_o  = err_addr_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_axi_decerr_slave.sv
// tb/tb_axi_decerr_slave.sv - directed bench for axi_decerr_slave (counter narrowed to 4 bits).
module tb_axi_decerr_slave;
  localparam int AW = 64, DW = 64, IW = 5, CW = 4;
  localparam logic [DW-1:0] RESP = 64'hDEAD_BEEF_DEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] aw_id, ar_id, b_id, r_id;
  logic [AW-1:0] aw_addr, ar_addr, err_addr;
  logic          aw_valid, aw_ready, w_last, w_valid, w_ready;
  logic [1:0]    b_resp, r_resp;
  logic          b_valid, b_ready;
  logic [7:0]    ar_len;
  logic          ar_valid, ar_ready, r_last, r_valid, r_ready;
  logic [DW-1:0] r_data;
  logic          err_valid, err_write, err_clr;
  logic [CW-1:0] err_cnt;
  int            total = 0, bad = 0;

  always #5 clk = ~clk;

  axi_decerr_slave #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .RespData(RESP), .CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_last_i(w_last), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_id_o(b_id), .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_id_i(ar_id), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_id_o(r_id), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last), .r_valid_o(r_valid), .r_ready_i(r_ready),
    .err_valid_o(err_valid), .err_write_o(err_write), .err_addr_o(err_addr), .err_cnt_o(err_cnt),
    .err_clr_i(err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (aw_ready !== 1'b1) begin bad++; $display("FAIL reset_aw_ready got=%b exp=1", aw_ready); end
    total++; if (ar_ready !== 1'b1) begin bad++; $display("FAIL reset_ar_ready got=%b exp=1", ar_ready); end
    total++; if ({w_ready, b_valid, r_valid, r_last} !== 4'b0000) begin bad++; $display("FAIL reset_valids got=%b exp=0000", {w_ready, b_valid, r_valid, r_last}); end
    total++; if ({b_id, r_id} !== 10'd0) begin bad++; $display("FAIL reset_ids got=%h exp=0", {b_id, r_id}); end
    total++; if ({err_valid, err_write, err_cnt} !== 6'd0 || err_addr !== 64'd0) begin bad++; $display("FAIL reset_err got=%b%b %h %h exp=0", err_valid, err_write, err_cnt, err_addr); end
  endtask

  task automatic test_single_write();
    aw_id = 5'h03; aw_addr = 64'h5000_0000; aw_valid = 1'b1;
    tick();
    aw_valid = 1'b0; w_valid = 1'b1; w_last = 1'b1; b_ready = 1'b1;
    total++; if ({aw_ready, w_ready, b_valid} !== 3'b010) begin bad++; $display("FAIL wr_after_aw got=%b exp=010", {aw_ready, w_ready, b_valid}); end
    total++; if (err_valid !== 1'b1 || err_write !== 1'b1 || err_addr !== 64'h5000_0000 || err_cnt !== 4'd1) begin bad++; $display("FAIL wr_capture got=%b%b %h %h exp=11 5000_0000 1", err_valid, err_write, err_addr, err_cnt); end
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    total++; if (b_valid !== 1'b1 || b_id !== 5'h03 || b_resp !== 2'b11) begin bad++; $display("FAIL wr_bresp got=%b %h %b exp=1 03 11", b_valid, b_id, b_resp); end
    total++; if (w_ready !== 1'b0) begin bad++; $display("FAIL wr_wready_resp got=%b exp=0", w_ready); end
    tick();
    b_ready = 1'b0;
    total++; if (b_valid !== 1'b0 || aw_ready !== 1'b1) begin bad++; $display("FAIL wr_done got=%b%b exp=01", b_valid, aw_ready); end
  endtask

  task automatic test_read_burst();
    int beats = 0;
    logic hold = 1'b0, prev_last = 1'b0;
    ar_id = 5'h11; ar_len = 8'd3; ar_addr = 64'h6000_0000; ar_valid = 1'b1;
    tick();
    ar_valid = 1'b0;
    total++; if (r_valid !== 1'b1 || r_id !== 5'h11 || ar_ready !== 1'b0) begin bad++; $display("FAIL rd_first got=%b %h %b exp=1 11 0", r_valid, r_id, ar_ready); end
    for (int c = 0; c < 40 && beats < 4; c++) begin
      r_ready = c[0];
      if (hold) begin
        total++; if (r_valid !== 1'b1 || r_last !== prev_last) begin bad++; $display("FAIL rd_stable got=%b%b exp=1%b", r_valid, r_last, prev_last); end
      end
      hold = r_valid && !r_ready;
      prev_last = r_last;
      if (r_valid && r_ready) begin
        beats++;
        total++; if (r_last !== (beats == 4)) begin bad++; $display("FAIL rd_last beat=%0d got=%b exp=%b", beats, r_last, beats == 4); end
        total++; if (r_data !== RESP || r_resp !== 2'b11) begin bad++; $display("FAIL rd_data got=%h %b exp=%h 11", r_data, r_resp, RESP); end
      end
      tick();
    end
    r_ready = 1'b0;
    total++; if (beats !== 4) begin bad++; $display("FAIL rd_beats got=%0d exp=4", beats); end
    total++; if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin bad++; $display("FAIL rd_idle got=%b%b exp=01", r_valid, ar_ready); end
    total++; if (err_cnt !== 4'd2 || err_write !== 1'b1 || err_addr !== 64'h5000_0000) begin bad++; $display("FAIL rd_sticky got=%h %b %h exp=2 1 5000_0000", err_cnt, err_write, err_addr); end
  endtask

  task automatic test_max_burst();
    int beats = 0, last_at = 0;
    ar_id = 5'h1F; ar_len = 8'd255; ar_addr = 64'h6000_1000; ar_valid = 1'b1;
    tick();
    ar_valid = 1'b0; r_ready = 1'b1;
    for (int c = 0; c < 300 && r_valid; c++) begin
      beats++;
      if (r_last && last_at == 0) last_at = beats;
      tick();
    end
    r_ready = 1'b0;
    total++; if (beats !== 256) begin bad++; $display("FAIL max_beats got=%0d exp=256", beats); end
    total++; if (last_at !== 256) begin bad++; $display("FAIL max_last_pos got=%0d exp=256", last_at); end
    total++; if (ar_ready !== 1'b1 || r_last !== 1'b0) begin bad++; $display("FAIL max_idle got=%b%b exp=10", ar_ready, r_last); end
  endtask

  task automatic test_concurrent();
    int held = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    aw_id = 5'h0A; aw_addr = 64'h7000_0000; aw_valid = 1'b1;
    ar_id = 5'h14; ar_addr = 64'h8000_0000; ar_len = 8'd1; ar_valid = 1'b1;
    tick();
    aw_valid = 1'b0; ar_valid = 1'b0; w_valid = 1'b1; w_last = 1'b1; r_ready = 1'b1; b_ready = 1'b0;
    total++; if (err_write !== 1'b1 || err_addr !== 64'h7000_0000 || err_cnt !== 4'd2) begin bad++; $display("FAIL cc_capture got=%b %h %h exp=1 7000_0000 2", err_write, err_addr, err_cnt); end
    total++; if (r_valid !== 1'b1 || r_id !== 5'h14 || w_ready !== 1'b1) begin bad++; $display("FAIL cc_both_busy got=%b %h %b exp=1 14 1", r_valid, r_id, w_ready); end
    tick();
    w_valid = 1'b0; w_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (b_valid === 1'b1 && aw_ready === 1'b0) held++;
      tick();
    end
    total++; if (held !== 10) begin bad++; $display("FAIL cc_b_hold got=%0d exp=10", held); end
    total++; if (r_valid !== 1'b0 || ar_ready !== 1'b1 || b_id !== 5'h0A) begin bad++; $display("FAIL cc_read_done got=%b%b %h exp=01 0a", r_valid, ar_ready, b_id); end
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0; r_ready = 1'b0;
    total++; if (b_valid !== 1'b0 || aw_ready !== 1'b1) begin bad++; $display("FAIL cc_b_done got=%b%b exp=01", b_valid, aw_ready); end
  endtask

  task automatic test_clear_saturation();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    total++; if (err_valid !== 1'b0 || err_cnt !== 4'd0 || err_addr !== 64'd0 || err_write !== 1'b0) begin bad++; $display("FAIL clr_plain got=%b %h %h %b exp=0 0 0 0", err_valid, err_cnt, err_addr, err_write); end
    ar_len = 8'd0; r_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ar_id = 5'h02; ar_addr = 64'h1000 + 64'(i) * 64'h40; ar_valid = 1'b1;
      tick();
      ar_valid = 1'b0;
      if (i == 0) begin
        total++; if (r_last !== 1'b1 || r_valid !== 1'b1) begin bad++; $display("FAIL sat_len0_last got=%b%b exp=11", r_valid, r_last); end
      end
      if (i == 13) begin
        total++; if (err_cnt !== 4'hE) begin bad++; $display("FAIL sat_cnt14 got=%h exp=e", err_cnt); end
      end
      tick();
    end
    total++; if (err_cnt !== 4'hF) begin bad++; $display("FAIL sat_cnt got=%h exp=f", err_cnt); end
    total++; if (err_addr !== 64'h1000 || err_write !== 1'b0) begin bad++; $display("FAIL sat_first_addr got=%h %b exp=1000 0", err_addr, err_write); end
    ar_addr = 64'h9000_0000_0000_1234; ar_valid = 1'b1; err_clr = 1'b1;
    tick();
    ar_valid = 1'b0; err_clr = 1'b0;
    total++; if (err_cnt !== 4'd1 || err_addr !== 64'h9000_0000_0000_1234 || err_valid !== 1'b1 || err_write !== 1'b0) begin bad++; $display("FAIL clr_evt_wins got=%h %h %b%b exp=1 9000000000001234 10", err_cnt, err_addr, err_valid, err_write); end
    tick();
    r_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    aw_id = 5'h07; aw_addr = 64'hA000; aw_valid = 1'b1;
    ar_id = 5'h08; ar_addr = 64'hB000; ar_len = 8'd7; ar_valid = 1'b1;
    tick();
    aw_valid = 1'b0; ar_valid = 1'b0; r_ready = 1'b1;
    tick();
    total++; if (r_valid !== 1'b1 || w_ready !== 1'b1 || r_last !== 1'b0) begin bad++; $display("FAIL mid_pre got=%b%b%b exp=110", r_valid, w_ready, r_last); end
    rst = 1'b1;
    tick();
    rst = 1'b0; r_ready = 1'b0;
    total++; if ({r_valid, w_ready, aw_ready, ar_ready, b_valid} !== 5'b00110) begin bad++; $display("FAIL mid_rst_fsm got=%b exp=00110", {r_valid, w_ready, aw_ready, ar_ready, b_valid}); end
    total++; if (err_cnt !== 4'd0 || err_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%h %b exp=0 0", err_cnt, err_valid); end
  endtask

  initial begin
    rst = 1'b1; aw_id = '0; aw_addr = '0; aw_valid = 1'b0; w_last = 1'b0; w_valid = 1'b0;
    b_ready = 1'b0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_valid = 1'b0; r_ready = 1'b0; err_clr = 1'b0;
    test_reset();
    test_single_write();
    test_read_burst();
    test_max_burst();
    test_concurrent();
    test_clear_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
